// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: special instruction words, bytes per word and
// the program-load state encoding.
package fetch_pkg;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

  typedef enum logic {
    LOADING = 1'b0,
    DONE    = 1'b1
  } load_state_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-serial program load port between the debug unit (master) and the
// instruction memory (slave).
interface instr_mem_loader_if #(
  parameter int NB_ADDR = 8
);

  // Handshake: a byte transfers on a rising edge where i_load_valid and
  // o_load_ready are both high, unless i_load_clear is also high (the byte is
  // dropped). The master holds i_load_byte stable while i_load_valid is high;
  // o_load_ready depends only on the loader state, never on i_load_valid.
  logic             i_load_valid;
  logic [7:0]       i_load_byte;
  logic             i_load_clear;
  logic             o_load_ready;
  logic             o_load_done;
  logic [NB_ADDR:0] o_word_count;

  modport master (
    output i_load_valid, i_load_byte, i_load_clear,
    input  o_load_ready, o_load_done, o_word_count
  );

  modport slave (
    input  i_load_valid, i_load_byte, i_load_clear,
    output o_load_ready, o_load_done, o_word_count
  );

endinterface

// File: rtl/load_byte_assembler.sv
// Packs accepted load bytes MSB-first into 32-bit words and pulses o_word_valid
// combinationally in the cycle the fourth byte of a word is accepted.
module load_byte_assembler
  import fetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  byte_idx;
  logic [23:0] assembly;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_idx <= '0;
      assembly <= '0;
    end else if (i_clear) begin
      byte_idx <= '0;
      assembly <= '0;
    end else if (i_accept) begin
      // Index wraps 3 -> 0 by itself; stale upper bytes shift out over the next word.
      byte_idx <= byte_idx + 2'd1;
      assembly <= {assembly[15:0], i_byte};
    end
  end

  assign o_word_valid = i_accept && (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {assembly, i_byte};

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction RAM read combinationally by the PC, written through a byte-serial
// load port. Define INSTR_MEM_HALT_DETECT_EN to end loading on a HALT_WORD.
module instr_mem_loader
  import fetch_pkg::*;
#(
  parameter int NB      = 32,
  parameter int NB_ADDR = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB-1:0]       i_pc,
  instr_mem_loader_if.slave   load,
  output logic [NB-1:0]       o_instruction,
  output logic                o_addr_fault,
  output load_state_t         o_state
);

  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB-1:0]      mem [DEPTH] = '{default: '0};
  load_state_t        state, state_nxt;
  logic [NB_ADDR-1:0] wptr;
  logic [NB_ADDR:0]   word_count;
  logic               accept, word_valid, halt_hit;
  logic [31:0]        word;
  logic [NB_ADDR-1:0] pc_index;

  assign accept = load.i_load_valid && load.o_load_ready && !load.i_load_clear;

  load_byte_assembler u_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (load.i_load_clear),
    .i_accept     (accept),
    .i_byte       (load.i_load_byte),
    .o_word_valid (word_valid),
    .o_word       (word)
  );

`ifdef INSTR_MEM_HALT_DETECT_EN
  assign halt_hit = is_halt(word);
`else
  assign halt_hit = 1'b0;
`endif

  // Array content survives reset so a debugger reset never wipes a loaded program.
  always_ff @(posedge i_clk) begin
    if (word_valid) mem[wptr] <= word;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= LOADING;
      wptr       <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (load.i_load_clear) begin
        wptr       <= '0;
        word_count <= '0;
      end else if (word_valid) begin
        wptr       <= wptr + 1'b1;
        word_count <= word_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (load.i_load_clear) begin
      state_nxt = LOADING;
    end else begin
      case (state)
        LOADING: if (word_valid && ((wptr == {NB_ADDR{1'b1}}) || halt_hit)) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = LOADING;
      endcase
    end
  end

  assign load.o_load_ready = (state == LOADING);
  assign load.o_load_done  = (state == DONE);
  assign load.o_word_count = word_count;
  assign o_state           = state;

  assign pc_index     = i_pc[NB_ADDR+1:2];
  assign o_addr_fault = (i_pc[1:0] != 2'b00) || (i_pc[NB-1:NB_ADDR+2] != '0);

  always_comb begin
    o_instruction = NOP_WORD;
    if (i_reset && !o_addr_fault) o_instruction = mem[pc_index];
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: drivers push expected output snapshots
// into a queue, a negedge monitor pops and compares them.
module tb_instr_mem_loader;
  import fetch_pkg::*;

  localparam int NB      = 32;
  localparam int NB_ADDR = 4;
  localparam int W       = 32 + 3 + NB_ADDR + 1;

  // ---------------- clock / reset ----------------
  logic          i_clk   = 1'b0;
  logic          i_reset = 1'b0;
  logic [NB-1:0] i_pc    = '0;
  logic [NB-1:0] o_instruction;
  logic          o_addr_fault;
  load_state_t   o_state;

  always #5 i_clk = ~i_clk;

  instr_mem_loader_if #(.NB_ADDR(NB_ADDR)) load_if ();

  instr_mem_loader #(.NB(NB), .NB_ADDR(NB_ADDR)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pc          (i_pc),
    .load          (load_if),
    .o_instruction (o_instruction),
    .o_addr_fault  (o_addr_fault),
    .o_state       (o_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic logic [W-1:0] pack(input logic [31:0] ins, input logic f, input logic r,
                                        input logic d, input logic [NB_ADDR:0] c);
    return {ins, f, r, d, c};
  endfunction

  always @(negedge i_clk) begin
    logic [W-1:0] exp_v, got_v;
    string        nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {o_instruction, o_addr_fault, load_if.o_load_ready,
               load_if.o_load_done, load_if.o_word_count};
      n_checks++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL %s: got instr=%h fault=%b ready=%b done=%b count=%0d, expected instr=%h fault=%b ready=%b done=%b count=%0d",
                    nm, got_v[W-1 -: 32], got_v[NB_ADDR+3], got_v[NB_ADDR+2], got_v[NB_ADDR+1], got_v[NB_ADDR:0],
                    exp_v[W-1 -: 32], exp_v[NB_ADDR+3], exp_v[NB_ADDR+2], exp_v[NB_ADDR+1], exp_v[NB_ADDR:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_out(input string nm, input logic [NB-1:0] pc, input logic [31:0] ins,
                            input logic f, input logic r, input logic d, input logic [NB_ADDR:0] c);
    i_pc = pc;
    exp_q.push_back(pack(ins, f, r, d, c));
    name_q.push_back(nm);
    @(negedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_if.i_load_valid = 1'b1;
    load_if.i_load_byte  = b;
    @(posedge i_clk);
    #1;
    load_if.i_load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_clear();
    load_if.i_load_clear = 1'b1;
    @(posedge i_clk);
    #1;
    load_if.i_load_clear = 1'b0;
  endtask

  function automatic logic [31:0] fill_word(input logic [7:0] i);
    return {i, 8'h5A, 8'hC3, ~i};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    load_if.i_load_valid = 1'b0;
    load_if.i_load_byte  = 8'h00;
    load_if.i_load_clear = 1'b0;

    expect_out("reset_state", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    expect_out("idle_read_pc0", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);

    // First word, with a same-cycle read before the writing edge
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    load_if.i_load_valid = 1'b1;
    load_if.i_load_byte  = 8'h78;
    expect_out("read_during_write_old", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    @(posedge i_clk); #1;
    load_if.i_load_valid = 1'b0;
    expect_out("first_word", 32'h0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd1);

    // Second word, then clear colliding with a valid byte
    send_word(32'hABCD_EF01);
    expect_out("second_word", 32'h4, 32'hABCD_EF01, 1'b0, 1'b1, 1'b0, 5'd2);
    load_if.i_load_valid = 1'b1;
    load_if.i_load_byte  = 8'hAA;
    pulse_clear();
    load_if.i_load_valid = 1'b0;
    expect_out("clear_resets_count", 32'h0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd0);
    send_word(32'h1122_3344);
    expect_out("overwrite_word0", 32'h0, 32'h1122_3344, 1'b0, 1'b1, 1'b0, 5'd1);
    expect_out("word1_kept", 32'h4, 32'hABCD_EF01, 1'b0, 1'b1, 1'b0, 5'd1);

    // Halt word handling
    pulse_clear();
    send_word(32'h8C01_0004);
    send_word(32'hFFFF_FFFF);
`ifdef INSTR_MEM_HALT_DETECT_EN
    expect_out("halt_word0", 32'h0, 32'h8C01_0004, 1'b0, 1'b0, 1'b1, 5'd2);
    expect_out("halt_word1", 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd2);
    send_word(32'h5555_5555);
    expect_out("after_halt_ignored", 32'h8, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2);
`else
    expect_out("halt_word0", 32'h0, 32'h8C01_0004, 1'b0, 1'b1, 1'b0, 5'd2);
    expect_out("halt_word1", 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd2);
    send_word(32'h5555_5555);
    expect_out("after_halt_loaded", 32'h8, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 5'd3);
`endif

    // Fill all 16 words
    pulse_clear();
    for (int i = 0; i < 15; i++) send_word(fill_word(8'(i)));
    expect_out("fill_15_words", 32'd56, 32'h0E5A_C3F1, 1'b0, 1'b1, 1'b0, 5'd15);
    send_word(fill_word(8'd15));
    expect_out("full_done", 32'd60, 32'h0F5A_C3F0, 1'b0, 1'b0, 1'b1, 5'd16);
    expect_out("pc_beyond_depth", 32'd64, 32'h0, 1'b1, 1'b0, 1'b1, 5'd16);
    expect_out("pc_misaligned", 32'd2, 32'h0, 1'b1, 1'b0, 1'b1, 5'd16);
    expect_out("pc_high_bit", 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 5'd16);
    send_word(32'h7777_7777);
    expect_out("full_refuses_bytes", 32'h0, 32'h005A_C3FF, 1'b0, 1'b0, 1'b1, 5'd16);

    // Asynchronous reset in the middle of a partial word
    pulse_clear();
    send_byte(8'hDE); send_byte(8'hAD);
    i_reset = 1'b0;
    expect_out("async_reset_outputs", 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    i_reset = 1'b1;
    expect_out("reset_keeps_memory", 32'h4, 32'h015A_C3FE, 1'b0, 1'b1, 1'b0, 5'd0);
    send_word(32'h0102_0304);
    expect_out("reload_word0", 32'h0, 32'h0102_0304, 1'b0, 1'b1, 1'b0, 5'd1);
    expect_out("reload_word1_kept", 32'h4, 32'h015A_C3FE, 1'b0, 1'b1, 1'b0, 5'd1);

    // ---------------- final report ----------------
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge i_clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d snapshots left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1, "watchdog");
  end

endmodule
